// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only come in B/H/W flavours; loads add the unsigned B/H variants.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) bad = !(f3 inside {F3_B, F3_H, F3_W});
    else    bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane extraction with extension for loads, and lane merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] byte_mask;
  logic [31:0] merged_b;
  logic [31:0] merged_h;

  // Halfwords only look at addr_lo[1], words at neither, so low bits drop out here.
  always_comb begin
    shamt     = {addr_lo, 3'b000};
    byte_val  = 8'(word >> shamt);
    half_val  = addr_lo[1] ? word[31:16] : word[15:0];
    byte_mask = 32'h0000_00FF << shamt;
    merged_b  = (word & ~byte_mask) | ({24'b0, wdata[7:0]} << shamt);
    merged_h  = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
  end

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_val = {24'b0, byte_val};
      F3_H:    load_val = {{16{half_val[15]}}, half_val};
      F3_HU:   load_val = {16'b0, half_val};
      F3_W:    load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word = merged_b;
      F3_H:    store_word = merged_h;
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word memory access with read-modify-write sub-word stores.
// Define MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [XLEN-1:0]   mem_read_data,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [XLEN-1:0]   mem_write_data,
  output logic              mem_we
);

  lsu_state_e state, state_next;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              req_illegal;
  logic              req_misaligned;
  logic [XLEN-1:0]   align_word;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   store_word;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign req_misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                          ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_illegal = funct3_illegal(req_we, req_funct3) || req_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_illegal ? RESP : ACCESS;
      end
      ACCESS: state_next = we_q ? WRITE : RESP;
      WRITE: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response fields are cleared at accept so a store or error reports zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_illegal;
          end
        end
        ACCESS: begin
          data_q  <= mem_read_data;
          rdata_q <= we_q ? '0 : load_val;
        end
        default: ;
      endcase
    end
  end

  // During ACCESS the live memory word feeds extraction; WRITE merges the sampled copy.
  assign align_word = (state == ACCESS) ? mem_read_data : data_q;

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign mem_read_addr  = addr_q[ADDR_W+1:2];
  assign mem_write_addr = addr_q[ADDR_W+1:2];
  assign mem_write_data = store_word;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-array memory model.
// Honours MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  mem_read_addr;
  logic [31:0] mem_read_data;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        mem_we;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        mem_load;
  int          we_count = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic [31:0] last_waddr;
  logic        last_err;

  load_store_unit #(.ADDR_W(5), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_we         (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
  endfunction

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= initWord(i);
    end else if (mem_we) begin
      mem[mem_write_addr] <= mem_write_data;
    end
  end

  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic modelErr(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    if (we) bad = (f3 > 3'd2);
    else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) bad = 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] word,
                                            input logic [31:0] addr);
    logic [7:0] bytes [4];
    int off, hoff, v;
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    off  = int'(addr % 4);
    hoff = 2 * int'((addr / 2) % 2);
    case (f3)
      3'd0: begin v = int'(bytes[off]); if (v > 127) v -= 256; return 32'(v); end
      3'd4: return 32'(int'(bytes[off]));
      3'd1: begin
        v = int'(bytes[hoff]) + 256 * int'(bytes[hoff+1]);
        if (v > 32767) v -= 65536;
        return 32'(v);
      end
      3'd5: return 32'(int'(bytes[hoff]) + 256 * int'(bytes[hoff+1]));
      3'd2: return word;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] modelStore(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0] bytes [4];
    int off, hoff;
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    off  = int'(addr % 4);
    hoff = 2 * int'((addr / 2) % 2);
    case (f3)
      3'd0: bytes[off] = wdata[7:0];
      3'd1: begin bytes[hoff] = wdata[7:0]; bytes[hoff+1] = wdata[15:8]; end
      default: for (int i = 0; i < 4; i++) bytes[i] = wdata[8*i +: 8];
    endcase
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  // One full transaction: drive, watch latencies, optionally hold the response, then retire.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata, exp_wdata, word;
    int          exp_rsp, exp_wec, rsp_cyc, we_cyc, we_before;
    logic [31:0] got_waddr, got_wdata, got_rdata;
    logic        got_err;
    word      = ref_mem[addr[6:2]];
    exp_err   = modelErr(we, f3, addr);
    exp_wdata = 32'h0;
    exp_rdata = 32'h0;
    if (exp_err) begin
      exp_rsp = 1; exp_wec = 0;
    end else if (we) begin
      exp_rsp = 3; exp_wec = 2;
      exp_wdata = modelStore(f3, word, addr, wdata);
    end else begin
      exp_rsp = 2; exp_wec = 0;
      exp_rdata = modelLoad(f3, word, addr);
    end
    rsp_cyc = 0; we_cyc = 0;
    got_waddr = 32'h0; got_wdata = 32'h0; got_rdata = 32'h0; got_err = 1'b0;

    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    we_before = we_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (mem_we && we_cyc == 0) begin
        we_cyc = k; got_waddr = 32'(mem_write_addr); got_wdata = mem_write_data;
      end
      if (rsp_valid) begin
        rsp_cyc = k; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    checkOutput("rsp_cycle", 32'(rsp_cyc), 32'(exp_rsp));
    checkOutput("we_cycle", 32'(we_cyc), 32'(exp_wec));
    checkOutput("rsp_err", 32'(got_err), 32'(exp_err));
    checkOutput("rsp_rdata", got_rdata, exp_rdata);
    if (exp_wec != 0) begin
      checkOutput("write_addr", got_waddr, 32'(addr[6:2]));
      checkOutput("write_data", got_wdata, exp_wdata);
    end
    if (hold > 0 && rsp_cyc != 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        checkOutput("hold_valid", 32'(rsp_valid), 32'h1);
        checkOutput("hold_rdata", rsp_rdata, got_rdata);
        checkOutput("hold_req_ready", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("rsp_drop", 32'(rsp_valid), 32'h0);
    checkOutput("back_to_idle", 32'(req_ready), 32'h1);
    checkOutput("we_pulses", 32'(we_count - we_before), (exp_wec != 0) ? 32'h1 : 32'h0);
    if (we && !exp_err) ref_mem[addr[6:2]] = exp_wdata;
    last_rdata = got_rdata; last_wdata = got_wdata; last_waddr = got_waddr; last_err = got_err;
  endtask

  task automatic resetDuringStore();
    int we_before;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'hCAFE_F00D;
    rsp_ready = 1'b1;
    we_before = we_count;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_idle", {30'h0, rsp_valid, req_ready}, 32'h1);
    end
    checkOutput("rst_no_write", 32'(we_count - we_before), 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = initWord(i);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_addrs", {22'h0, mem_read_addr, mem_write_addr}, 32'h0);
    checkOutput("reset_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_load = 1'b0;

    applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0);
    checkOutput("sw_lit_addr", last_waddr, 32'h2);
    checkOutput("sw_lit_data", last_wdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 0);
    checkOutput("lw_lit", last_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b000, 32'h9, 32'h0, 0);
    checkOutput("lb_lit", last_rdata, 32'hFFFF_FFBE);
    applyStimulus(1'b0, 3'b100, 32'h9, 32'h0, 0);
    checkOutput("lbu_lit", last_rdata, 32'h0000_00BE);
    applyStimulus(1'b0, 3'b001, 32'hA, 32'h0, 0);
    checkOutput("lh_lit", last_rdata, 32'hFFFF_DEAD);
    applyStimulus(1'b0, 3'b101, 32'hA, 32'h0, 0);
    checkOutput("lhu_lit", last_rdata, 32'h0000_DEAD);
    applyStimulus(1'b1, 3'b000, 32'h9, 32'h1234_5677, 0);
    checkOutput("sb_lit", last_wdata, 32'hDEAD_77EF);
    applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 3'b001, 32'hA, 32'hAAAA_5555, 0);
    checkOutput("sh_lit", last_wdata, 32'h5555_BEEF);
    applyStimulus(1'b0, 3'b011, 32'h8, 32'h0, 0);
    checkOutput("illegal_load_err", 32'(last_err), 32'h1);
    applyStimulus(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF, 0);
    checkOutput("illegal_store_err", 32'(last_err), 32'h1);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 5);
    applyStimulus(1'b0, 3'b100, 32'hB, 32'h0, 0);
    resetDuringStore();
    applyStimulus(1'b0, 3'b001, 32'h5, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("lh_misaligned_err", 32'(last_err), 32'h1);
`else
    checkOutput("lh_misaligned_err", 32'(last_err), 32'h0);
`endif

    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
